// File: rtl/mem_stage.sv
// MIPS pipeline memory stage: EX/MEM register, data-cache handshake, MEM/WB register.
// Stalls the upstream pipe while the cache is busy and counts stall cycles.
module mem_stage #(
   parameter int unsigned MIPS_BUS = 32,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [MIPS_BUS-1:0] ALU_Result,
   input  logic [MIPS_BUS-1:0] Write_DataIN,
   input  logic [4:0]          Write_RegIN,
   input  logic                MemRead,
   input  logic                MemWrite,
   input  logic                RegWrite,
   input  logic                MemtoReg,
   input  logic [MIPS_BUS-1:0] DCACHE_rdata,
   input  logic                DCACHE_stall,
   output logic                DCACHE_ren,
   output logic                DCACHE_wen,
   output logic [MIPS_BUS-3:0] DCACHE_addr,
   output logic [MIPS_BUS-1:0] DCACHE_wdata,
   output logic [MIPS_BUS-1:0] EX_MEMALUResult,
   output logic [4:0]          EX_MEM_Rd,
   output logic                EX_MEM_RegWrite,
   output logic [MIPS_BUS-1:0] MEM_WBWriteDATA,
   output logic [4:0]          MEM_WB_Rd,
   output logic                MEM_WB_RegWrite,
   output logic                mem_stall,
   output logic                misalign_err,
   output logic [CNT_W-1:0]    stall_cycles
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t state, state_nxt;

   logic [MIPS_BUS-1:0] alu_q, wdata_q;
   logic [4:0]          rd_q;
   logic                memread_q, memwrite_q, regwrite_q, memtoreg_q;
   logic                mem_op;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_q      <= '0;
         wdata_q    <= '0;
         rd_q       <= '0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
      end else if (!mem_stall) begin
         alu_q      <= ALU_Result;
         wdata_q    <= Write_DataIN;
         rd_q       <= Write_RegIN;
         memread_q  <= MemRead;
         memwrite_q <= MemWrite;
         regwrite_q <= RegWrite;
         memtoreg_q <= MemtoReg;
      end
   end

   // Read+write together is illegal; it is treated as a write, so ren is masked.
   assign mem_op       = memread_q | memwrite_q;
   assign DCACHE_ren   = memread_q & ~memwrite_q;
   assign DCACHE_wen   = memwrite_q;
   assign DCACHE_addr  = alu_q[MIPS_BUS-1:2];
   assign DCACHE_wdata = wdata_q;
   assign mem_stall    = mem_op & DCACHE_stall;

   assign EX_MEMALUResult = alu_q;
   assign EX_MEM_Rd       = rd_q;
   assign EX_MEM_RegWrite = regwrite_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (mem_op && DCACHE_stall) state_nxt = BUSY;
         BUSY: if (!DCACHE_stall)          state_nxt = IDLE;
         default:                          state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         MEM_WBWriteDATA <= '0;
         MEM_WB_Rd       <= '0;
         MEM_WB_RegWrite <= 1'b0;
      end else if (!mem_stall) begin
         MEM_WBWriteDATA <= memtoreg_q ? DCACHE_rdata : alu_q;
         MEM_WB_Rd       <= rd_q;
         MEM_WB_RegWrite <= regwrite_q;
      end else begin
         MEM_WB_RegWrite <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         misalign_err <= 1'b0;
         stall_cycles <= '0;
      end else begin
         if (mem_op && !DCACHE_stall && (alu_q[1:0] != 2'b00)) misalign_err <= 1'b1;
         if (mem_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      end
   end

endmodule
